// File: rtl/washer_fsmw_pkg.sv
// Shared definitions for the washing-machine program controller:
// state encodings, program codes, motor codes, default phase durations
// and the phase-sequencing helpers used by the controller.
package washer_fsmw_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FILL      = 4'd1,
    ST_WAIT_SOAP = 4'd2,
    ST_WASH      = 4'd3,
    ST_DRAIN1    = 4'd4,
    ST_RINSE     = 4'd5,
    ST_DRAIN2    = 4'd6,
    ST_SPIN      = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    PROG_COLD_WASH   = 3'b000,
    PROG_HOT_WASH    = 3'b001,
    PROG_RINSING_DRY = 3'b010,
    PROG_ONLY_DRY    = 3'b011
  } prog_t;

  localparam logic [1:0] MOTOR_OFF     = 2'b00;
  localparam logic [1:0] MOTOR_AGITATE = 2'b01;
  localparam logic [1:0] MOTOR_SPIN    = 2'b10;

  localparam int DEF_FILL_T  = 10;
  localparam int DEF_WASH_T  = 30;
  localparam int DEF_DRAIN_T = 10;
  localparam int DEF_RINSE_T = 20;
  localparam int DEF_SPIN_T  = 20;

  // Codes with the MSB set are not programs.
  function automatic logic prog_valid(input logic [2:0] code);
    return (code[2] == 1'b0);
  endfunction

  // Phase a freshly accepted program starts in.
  function automatic state_t first_phase(input prog_t p);
    state_t s;
    s = ST_SPIN;
    case (p)
      PROG_COLD_WASH,
      PROG_HOT_WASH:    s = ST_FILL;
      PROG_RINSING_DRY: s = ST_RINSE;
      default:          s = ST_SPIN;
    endcase
    return s;
  endfunction

  // Phase following a completed one. All programs share the tail of the
  // chain, so the program code only matters for the entry phase.
  function automatic state_t phase_after(input state_t s, input logic soap_present);
    state_t nxt;
    nxt = s;
    case (s)
      ST_FILL:   nxt = soap_present ? ST_WASH : ST_WAIT_SOAP;
      ST_WASH:   nxt = ST_DRAIN1;
      ST_DRAIN1: nxt = ST_RINSE;
      ST_RINSE:  nxt = ST_DRAIN2;
      ST_DRAIN2: nxt = ST_SPIN;
      ST_SPIN:   nxt = ST_DONE;
      default:   nxt = s;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/washer_fsmw_phase_timer.sv
// Loadable down-counter that measures the length of the current phase.
// It is loaded with (duration - 1); the phase ends on the enabled cycle in
// which the counter already reads zero.
module washer_fsmw_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_reg;

  // Load has priority over counting; the counter saturates at zero.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/washer_fsmw.sv
// Washing-machine program controller. Accepts a program and a start
// request, sequences the fill/wash/drain/rinse/spin phases, drives the
// valves, soap dispenser and motor, and shows the remaining cycle count.
// Actuator outputs are registered from the current state, so they follow
// a state change by one clock.
module washer_fsmw
  import washer_fsmw_pkg::*;
#(
  parameter int FILL_T  = DEF_FILL_T,
  parameter int WASH_T  = DEF_WASH_T,
  parameter int DRAIN_T = DEF_DRAIN_T,
  parameter int RINSE_T = DEF_RINSE_T,
  parameter int SPIN_T  = DEF_SPIN_T
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power,
  input  logic [2:0] program_selection,
  input  logic       start,
  input  logic       doorclosed,
  input  logic       soap,
  output logic       valve_in_cold,
  output logic       valve_in_hot,
  output logic       valve_out,
  output logic [1:0] motor,
  output logic [7:0] timer_display,
  output logic       program_done,
  output logic       soap_warning,
  output logic       soap_in
);

  localparam logic [7:0] TOTAL_WASH  = 8'(FILL_T + WASH_T + 2 * DRAIN_T + RINSE_T + SPIN_T);
  localparam logic [7:0] TOTAL_RINSE = 8'(RINSE_T + DRAIN_T + SPIN_T);
  localparam logic [7:0] TOTAL_DRY   = 8'(SPIN_T);

  state_t     current_state;
  prog_t      prog_reg;
  logic [7:0] timer_reg;

  logic       clear;
  logic       running;
  logic       active;
  logic       accept;
  logic       soap_ready;
  logic       ph_zero;
  logic       ph_load;
  logic [7:0] ph_load_val;
  logic       ph_en;
  state_t     next_phase;
  prog_t      sel_prog;

  // Counter preload for a phase (its duration minus one).
  function automatic logic [7:0] phase_preload(input state_t s);
    logic [7:0] v;
    v = '0;
    case (s)
      ST_FILL:   v = 8'(FILL_T - 1);
      ST_WASH:   v = 8'(WASH_T - 1);
      ST_DRAIN1,
      ST_DRAIN2: v = 8'(DRAIN_T - 1);
      ST_RINSE:  v = 8'(RINSE_T - 1);
      ST_SPIN:   v = 8'(SPIN_T - 1);
      default:   v = '0;
    endcase
    return v;
  endfunction

  // Whole-program cycle count shown on the display at acceptance.
  function automatic logic [7:0] program_total(input prog_t p);
    logic [7:0] v;
    v = TOTAL_DRY;
    case (p)
      PROG_COLD_WASH,
      PROG_HOT_WASH:    v = TOTAL_WASH;
      PROG_RINSING_DRY: v = TOTAL_RINSE;
      default:          v = TOTAL_DRY;
    endcase
    return v;
  endfunction

  // Power-off behaves exactly like reset.
  assign clear    = rst | ~power;
  assign sel_prog = prog_t'(program_selection);

  // Qualifiers for acceptance, pausing and phase advancement.
  always_comb begin
    running    = (current_state == ST_FILL)   || (current_state == ST_WASH)  ||
                 (current_state == ST_DRAIN1) || (current_state == ST_RINSE) ||
                 (current_state == ST_DRAIN2) || (current_state == ST_SPIN);
    active     = running && doorclosed;
    accept     = ((current_state == ST_IDLE) || (current_state == ST_DONE)) &&
                 start && doorclosed && prog_valid(program_selection);
    soap_ready = (current_state == ST_WAIT_SOAP) && soap && doorclosed;
    next_phase = phase_after(current_state, soap);
  end

  // Phase counter control: reload on acceptance, on leaving the soap wait
  // and whenever a phase hands over to another timed phase.
  always_comb begin
    ph_load     = 1'b0;
    ph_load_val = '0;
    if (accept) begin
      ph_load     = 1'b1;
      ph_load_val = phase_preload(first_phase(sel_prog));
    end else if (soap_ready) begin
      ph_load     = 1'b1;
      ph_load_val = phase_preload(ST_WASH);
    end else if (active && ph_zero) begin
      ph_load     = 1'b1;
      ph_load_val = phase_preload(next_phase);
    end
    ph_en = active && !ph_zero;
  end

  washer_fsmw_phase_timer #(
    .W(8)
  ) u_phase_timer (
    .clk       (clk),
    .srst      (clear),
    .load      (ph_load),
    .load_value(ph_load_val),
    .en        (ph_en),
    .zero      (ph_zero)
  );

  // Program state machine with registered actuator and status outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      current_state <= ST_IDLE;
      prog_reg      <= PROG_COLD_WASH;
      timer_reg     <= '0;
      valve_in_cold <= 1'b0;
      valve_in_hot  <= 1'b0;
      valve_out     <= 1'b0;
      motor         <= MOTOR_OFF;
      soap_in       <= 1'b0;
      soap_warning  <= 1'b0;
      program_done  <= 1'b0;
    end else begin
      // An open door silences every actuator of a running phase.
      valve_in_cold <= doorclosed &&
                       (((current_state == ST_FILL) && (prog_reg == PROG_COLD_WASH)) ||
                        (current_state == ST_RINSE));
      valve_in_hot  <= doorclosed && (current_state == ST_FILL) && (prog_reg == PROG_HOT_WASH);
      valve_out     <= doorclosed && ((current_state == ST_DRAIN1) ||
                                      (current_state == ST_DRAIN2) ||
                                      (current_state == ST_SPIN));
      soap_in       <= doorclosed && (current_state == ST_WASH);
      if (!doorclosed) begin
        motor <= MOTOR_OFF;
      end else if ((current_state == ST_WASH) || (current_state == ST_RINSE)) begin
        motor <= MOTOR_AGITATE;
      end else if (current_state == ST_SPIN) begin
        motor <= MOTOR_SPIN;
      end else begin
        motor <= MOTOR_OFF;
      end
      soap_warning  <= (current_state == ST_WAIT_SOAP);
      program_done  <= (current_state == ST_DONE);

      if (accept) begin
        current_state <= first_phase(sel_prog);
        prog_reg      <= sel_prog;
        timer_reg     <= program_total(sel_prog);
      end else if (soap_ready) begin
        current_state <= ST_WASH;
      end else if (active) begin
        timer_reg <= timer_reg - 1'b1;
        if (ph_zero) begin
          current_state <= next_phase;
        end
      end
    end
  end

  assign timer_display = timer_reg;

endmodule

// File: tb/tb_washer_fsmw.sv
// Directed and random bench for the washing-machine controller. For each
// program the expected per-cycle output vector is queued when the start is
// driven, then popped and compared every clock.
module tb_washer_fsmw;
  import washer_fsmw_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       power;
  logic [2:0] program_selection;
  logic       start;
  logic       doorclosed;
  logic       soap;
  logic       valve_in_cold;
  logic       valve_in_hot;
  logic       valve_out;
  logic [1:0] motor;
  logic [7:0] timer_display;
  logic       program_done;
  logic       soap_warning;
  logic       soap_in;

  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  washer_fsmw dut (
    .clk              (clk),
    .rst              (rst),
    .power            (power),
    .program_selection(program_selection),
    .start            (start),
    .doorclosed       (doorclosed),
    .soap             (soap),
    .valve_in_cold    (valve_in_cold),
    .valve_in_hot     (valve_in_hot),
    .valve_out        (valve_out),
    .motor            (motor),
    .timer_display    (timer_display),
    .program_done     (program_done),
    .soap_warning     (soap_warning),
    .soap_in          (soap_in)
  );

  // {cold, hot, out, motor[1:0], soap_in, warn, done, timer[7:0]}
  function automatic logic [15:0] obs_vec();
    return {valve_in_cold, valve_in_hot, valve_out, motor, soap_in,
            soap_warning, program_done, timer_display};
  endfunction

  function automatic logic [15:0] mk(bit c, bit h, bit o, logic [1:0] m, bit si,
                                     bit w, bit d, int t);
    return {c, h, o, m, si, w, d, 8'(t)};
  endfunction

  // Phase ids: 1 fill, 3 wash, 4 drain, 5 rinse, 7 spin.
  function automatic logic [15:0] phase_vec(int ph, int prog, int t);
    logic [15:0] v;
    v = mk(0, 0, 0, 2'b00, 0, 0, 0, t);
    case (ph)
      1: v = mk(prog == 0, prog == 1, 0, 2'b00, 0, 0, 0, t);
      3: v = mk(0, 0, 0, 2'b01, 1, 0, 0, t);
      4: v = mk(0, 0, 1, 2'b00, 0, 0, 0, t);
      5: v = mk(1, 0, 0, 2'b01, 0, 0, 0, t);
      7: v = mk(0, 0, 1, 2'b10, 0, 0, 0, t);
      default: v = mk(0, 0, 0, 2'b00, 0, 0, 0, t);
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total_cnt++;
    assert (obs === expv)
    else begin
      bad_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Queue the expected output of every clock after acceptance.
  task automatic build(input int prog, input int wait_n, input int door_p,
                       input int door_len, output int total);
    int phs[$];
    int lens[$];
    int k;
    phs.delete();
    lens.delete();
    if (prog <= 1) begin
      phs = '{1, 3, 4, 5, 4, 7};
      lens = '{10, 30, 10, 20, 10, 20};
    end else if (prog == 2) begin
      phs = '{5, 4, 7};
      lens = '{20, 10, 20};
    end else begin
      phs = '{7};
      lens = '{20};
    end
    total = 0;
    foreach (lens[i]) total += lens[i];
    k = 0;
    foreach (phs[i]) begin
      for (int j = 0; j < lens[i]; j++) begin
        k++;
        if (door_p > 0 && k == door_p)
          for (int p = 0; p < door_len; p++) exp_q.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, total - (k - 1)));
        exp_q.push_back(phase_vec(phs[i], prog, total - k));
        if (phs[i] == 1 && j == lens[i] - 1)
          for (int p = 0; p < wait_n; p++) exp_q.push_back(mk(0, 0, 0, 2'b00, 0, 1, 0, total - k));
      end
    end
    exp_q.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 0));
  endtask

  // Start a program, then compare every clock until DONE has shown up.
  task automatic run(input string tag, input int prog, input int wait_n,
                     input int door_p, input int door_len);
    int total;
    int n;
    exp_q.delete();
    build(prog, wait_n, door_p, door_len, total);
    program_selection = 3'(prog);
    start = 1'b1;
    doorclosed = 1'b1;
    soap = (wait_n == 0);
    tick();
    check({tag, "_load"}, {8'h00, timer_display}, 16'(total));
    start = 1'b0;
    n = exp_q.size();
    for (int e = 1; e <= n; e++) begin
      program_selection = 3'($urandom_range(0, 7));
      soap = (wait_n == 0) ? 1'b1 : (e >= 10 + wait_n);
      doorclosed = !(door_p > 0 && e >= door_p && e < door_p + door_len);
      tick();
      check($sformatf("%s_e%0d", tag, e), obs_vec(), exp_q.pop_front());
    end
    doorclosed = 1'b1;
    soap = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    power = 1'b1;
    start = 1'b0;
    doorclosed = 1'b1;
    soap = 1'b1;
    program_selection = 3'b000;
    tick();
    tick();
    check("reset", obs_vec(), 16'h0000);
    rst = 1'b0;

    // Invalid code and open door must not start anything.
    program_selection = 3'b111;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bad_code", obs_vec(), 16'h0000);
    end
    program_selection = 3'b000;
    doorclosed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("door_open_start", obs_vec(), 16'h0000);
    end
    start = 1'b0;
    doorclosed = 1'b1;

    run("cold", 0, 0, 0, 0);
    run("hot_wait", 1, 6, 0, 0);
    run("rinse_dry", 2, 0, 0, 0);
    run("only_dry", 3, 0, 0, 0);
    run("door_pause", 0, 0, 20, 5);

    // Power loss in the middle of spin aborts to idle with no resume.
    program_selection = 3'b011;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("mid_spin", obs_vec(), mk(0, 0, 1, 2'b10, 0, 0, 0, 15));
    power = 1'b0;
    tick();
    check("power_off", obs_vec(), 16'h0000);
    power = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("after_power", obs_vec(), 16'h0000);
    end

    // Random stress on the actuator safety invariants.
    for (int i = 0; i < 3000; i++) begin
      program_selection = 3'($urandom_range(0, 7));
      start = ($urandom_range(0, 9) == 0);
      doorclosed = ($urandom_range(0, 7) != 0);
      soap = ($urandom_range(0, 3) != 0);
      power = ($urandom_range(0, 199) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      check("stress_motor", {15'h0, motor === 2'b11}, 16'h0000);
      check("stress_valves", {15'h0, valve_in_cold & valve_in_hot}, 16'h0000);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("final_idle", obs_vec(), 16'h0000);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
